alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 64-bit ALU in the CPU datapath. It accepts operation requests (operands plus 4-bit ALU control) from two clients over valid/ready handshakes and grants the ALU round-robin. It registers the operands onto the ALU inputs, captures the ALU result and zero flag, and returns them, tagged with the requester ID, over a valid/ready response channel. It sits between the execute-stage clients and the single ALU instance, so the ALU itself stays purely combinational.

## Interface
- N, default 63: MSB index of the data path (data width is N+1).
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  N+1  requester 0 operands.
- req0_ctrl  input  4  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same roles and widths as requester 0.
- alu_a, alu_b  output  N+1  registered operands driven to the ALU.
- alu_ctrl  output  4  registered control code driven to the ALU.
- alu_result  input  N+1  ALU combinational result.
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  response holds a completed result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the response (0 or 1).
- rsp_result  output  N+1  captured ALU result.
- rsp_zero  output  1  captured ALU zero flag.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If neither requester is valid, stay in IDLE.
  - Otherwise select a grant:
    - Only one requester valid: grant that one.
    - Both valid: grant the requester that is not last_grant.
  - Assert readyX for the granted requester only. This is combinational and the only cycle in which readyX can be high.
  - On the clock edge:
    - Load alu_a, alu_b, alu_ctrl from the granted requester.
    - Load the ID register with the grant.
    - Set last_grant to the grant.
    - Go to EXEC.
- EXEC:
  - The ALU settles on the registered operands.
  - On the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP.
- RESP:
  - rsp_valid is 1.
  - If rsp_ready is 1, go to IDLE on the edge. Otherwise hold RESP with all rsp_* outputs stable.
- last_grant resets to 1, so requester 0 wins the first contention.
- The ctrl code passes through unmodified. Undefined codes are not filtered; the ALU default (add) applies.
- Requesters must hold valid and operands stable until ready. The arbiter never drops an asserted valid.
- alu_a, alu_b and alu_ctrl hold their last value outside EXEC. No ALU activity is required in IDLE.
- Reset asserted in any state:
  - Go to IDLE immediately (asynchronously).
  - Any in-flight transaction is discarded. No response is produced for it.

## Timing
- Reset values:
  - Outputs: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, alu_a=0, alu_b=0, alu_ctrl=4'b0000, busy=0, req0_ready=0, req1_ready=0.
  - Internal: last_grant=1.
- Latency, with acceptance in cycle 0 (valid and ready both high):
  - Cycle 1: EXEC, ALU inputs valid.
  - Cycle 2: rsp_valid=1.
- The earliest next acceptance is the cycle after rsp_valid&&rsp_ready.
- Maximum throughput is one operation per 3 cycles.
- readyX is combinational from state, valid and last_grant. It never depends on operand values.
- rsp_* are registered with no combinational path from rsp_ready.
- A valid that rises during EXEC or RESP waits. It is arbitrated in the first IDLE cycle.

## Test plan
- Single request:
  - Stimulus: req0 with a=64'hF0F0, b=64'h0FF0, ctrl=0000.
  - Required response: req0_ready high in cycle 0; rsp_valid in cycle 2 with rsp_result=64'h00F0, rsp_zero=0, rsp_id=0.
- Contention after reset:
  - Stimulus: both requesters valid; req0 add 5+7, req1 sub 9-9; rsp_ready held at 1.
  - Required response: first response id=0 with result 12; second response id=1 with result 0 and rsp_zero=1. The second acceptance occurs 3 cycles after the first.
- Fairness:
  - Stimulus: both requesters valid continuously for 6 operations.
  - Required response: grants alternate 0,1,0,1,0,1.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles in RESP while req1 is valid.
  - Required response: rsp_* stable and busy=1 throughout; req1_ready stays 0 until the cycle after rsp_ready=1.
- Reset during EXEC:
  - Stimulus: assert reset mid-cycle while in EXEC.
  - Required response: outputs return to reset values immediately; no rsp_valid for the discarded operation; a subsequent req1-only request is granted normally.
- Control passthrough:
  - Stimulus: ctrl=0110 with a=3, b=5, then ctrl=1111 with a=3, b=5.
  - Required response: alu_ctrl equals the requested code during EXEC each time; rsp_result=64'hFFFF_FFFF_FFFF_FFFE for the 0110 operation and 8 for the 1111 operation.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Round-robin arbiter/sequencer in front of the single shared 64-bit ALU.
//   Two clients issue (a, b, ctrl) over valid/ready; the granted operation is
//   registered onto the ALU inputs, the ALU result/zero flag are captured one
//   cycle later and returned with the requester ID over a valid/ready response.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   reqX_valid / reqX_ready     request handshake for client X (0, 1)
//   reqX_a, reqX_b, reqX_ctrl   operands and ALU control code for client X
//   alu_a, alu_b, alu_ctrl      registered operands/control to the ALU
//   alu_result, alu_zero        combinational ALU outputs
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_result, rsp_zero  registered response payload
//   busy                        high whenever an operation is in flight
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int N = 63
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N:0]   req0_a,
    input  logic [N:0]   req0_b,
    input  logic [3:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N:0]   req1_a,
    input  logic [N:0]   req1_b,
    input  logic [3:0]   req1_ctrl,
    output logic [N:0]   alu_a,
    output logic [N:0]   alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N:0]   alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N:0]   rsp_result,
    output logic         rsp_zero,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_q;
    logic       id_q;
    logic [N:0] a_q, b_q, res_q;
    logic [3:0] ctrl_q;
    logic       zero_q;

    logic any_valid;
    logic grant;
    logic accept;

    // Grant depends only on state, valids and last_grant: a lone requester
    // wins outright, contention goes to whoever was not served last.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        accept     = (state_q == IDLE) && any_valid;
        req0_ready = accept & ~grant;
        req1_ready = accept &  grant;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;   // requester 0 wins the first contention
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 4'b0000;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= grant;
                id_q   <= grant;
                a_q    <= grant ? req1_a    : req0_a;
                b_q    <= grant ? req1_b    : req0_b;
                ctrl_q <= grant ? req1_ctrl : req0_ctrl;
            end
            // ALU has had a full cycle to settle on the registered operands.
            if (state_q == EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Self-checking bench: the bench plays the ALU and both clients, and keeps a
//   transaction-level reference (one outstanding op, response due two cycles
//   after acceptance, held until consumed) that every cycle is compared with.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic        clk;
    logic        reset;
    logic        v [2];
    logic [63:0] a [2];
    logic [63:0] b [2];
    logic [3:0]  c [2];
    logic        req0_ready, req1_ready;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [63:0] rsp_result;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    bit          m_have;
    int          m_acc;
    int          m_cyc;
    logic        m_last;
    logic        m_id;
    logic [63:0] m_a, m_b, m_res;
    logic [3:0]  m_c;
    logic        m_zero;

    // observed DUT activity
    int          g_log[$];
    int          c_log[$];
    int          r_id[$];
    int          r_cyc[$];
    logic [63:0] r_res[$];
    logic        r_zero[$];

    alu_share_arbiter #(.N(63)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v[0]), .req0_ready(req0_ready),
        .req0_a(a[0]), .req0_b(b[0]), .req0_ctrl(c[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready),
        .req1_a(a[1]), .req1_b(b[1]), .req1_ctrl(c[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] alu_fn(input logic [63:0] x, input logic [63:0] y,
                                           input logic [3:0] op);
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return {63'd0, ($signed(x) < $signed(y))};
            4'b1100: return ~(x | y);
            default: return x + y;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
        alu_zero   = (alu_result == 64'd0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_acc = 0; m_last = 1'b1; m_id = 1'b0;
        m_a = '0; m_b = '0; m_c = '0; m_res = '0; m_zero = 1'b0;
    endtask

    task automatic set_op(input int r, input logic [63:0] x, input logic [63:0] y,
                          input logic [3:0] op);
        a[r] = x; b[r] = y; c[r] = op; v[r] = 1'b1;
    endtask

    // One clock cycle: compare at the falling edge, advance the model on the
    // rising edge, release an accepted request just after it.
    task automatic step();
        logic any, g, exp_rv, took;
        @(negedge clk);
        any    = v[0] | v[1];
        g      = (v[0] && v[1]) ? ~m_last : v[1];
        exp_rv = m_have && (m_cyc >= m_acc + 2);
        chk("req0_ready", 64'(req0_ready), 64'(!m_have && any && !g));
        chk("req1_ready", 64'(req1_ready), 64'(!m_have && any && g));
        chk("rsp_valid",  64'(rsp_valid),  64'(exp_rv));
        chk("busy",       64'(busy),       64'(m_have));
        chk("alu_a",      alu_a,           m_a);
        chk("alu_b",      alu_b,           m_b);
        chk("alu_ctrl",   64'(alu_ctrl),   64'(m_c));
        if (exp_rv) begin
            chk("rsp_id",     64'(rsp_id),   64'(m_id));
            chk("rsp_result", rsp_result,    m_res);
            chk("rsp_zero",   64'(rsp_zero), 64'(m_zero));
        end
        if (req0_ready) begin g_log.push_back(0); c_log.push_back(m_cyc); end
        if (req1_ready) begin g_log.push_back(1); c_log.push_back(m_cyc); end
        if (rsp_valid && rsp_ready) begin
            r_id.push_back(int'(rsp_id)); r_res.push_back(rsp_result);
            r_zero.push_back(rsp_zero);   r_cyc.push_back(m_cyc);
        end
        @(posedge clk);
        took = 1'b0;
        if (!m_have && any) begin
            m_last = g; m_id = g;
            m_a = a[g]; m_b = b[g]; m_c = c[g];
            m_res  = alu_fn(m_a, m_b, m_c);
            m_zero = (m_res == 64'd0);
            m_have = 1; m_acc = m_cyc; took = 1'b1;
        end else if (exp_rv && rsp_ready) begin
            m_have = 0;
        end
        m_cyc++;
        #1;
        if (took) v[g] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; v[0] = 1'b0; v[1] = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        chk("rst_rsp_id",     64'(rsp_id),     64'd0);
        chk("rst_rsp_result", rsp_result,      64'd0);
        chk("rst_rsp_zero",   64'(rsp_zero),   64'd0);
        chk("rst_alu_a",      alu_a,           64'd0);
        chk("rst_alu_b",      alu_b,           64'd0);
        chk("rst_alu_ctrl",   64'(alu_ctrl),   64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_rdy0",       64'(req0_ready), 64'd0);
        chk("rst_rdy1",       64'(req1_ready), 64'd0);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        int gb, rb;
        reset = 1'b1; rsp_ready = 1'b0; m_cyc = 0;
        for (int r = 0; r < 2; r++) begin v[r] = 0; a[r] = '0; b[r] = '0; c[r] = '0; end
        model_reset();

        // single request: AND, response two cycles after acceptance
        do_reset();
        rsp_ready = 1'b1;
        gb = g_log.size(); rb = r_res.size();
        set_op(0, 64'hF0F0, 64'h0FF0, 4'b0000);
        repeat (4) step();
        chk("single_grant", 64'(g_log[gb]), 64'd0);
        chk("single_res",   r_res[rb],      64'h00F0);
        chk("single_zero",  64'(r_zero[rb]), 64'd0);
        chk("single_id",    64'(r_id[rb]),  64'd0);
        chk("single_lat",   64'(r_cyc[rb] - c_log[gb]), 64'd2);

        // contention straight after reset: requester 0 first
        do_reset();
        rsp_ready = 1'b1;
        gb = g_log.size(); rb = r_res.size();
        set_op(0, 64'd5, 64'd7, 4'b0010);
        set_op(1, 64'd9, 64'd9, 4'b0110);
        repeat (7) step();
        chk("cont_id0",   64'(r_id[rb]),       64'd0);
        chk("cont_res0",  r_res[rb],           64'd12);
        chk("cont_id1",   64'(r_id[rb+1]),     64'd1);
        chk("cont_res1",  r_res[rb+1],         64'd0);
        chk("cont_zero1", 64'(r_zero[rb+1]),   64'd1);
        chk("cont_gap",   64'(c_log[gb+1] - c_log[gb]), 64'd3);

        // fairness: both clients always pending
        do_reset();
        rsp_ready = 1'b1;
        gb = g_log.size();
        repeat (20) begin
            for (int r = 0; r < 2; r++)
                if (!v[r]) set_op(r, 64'($urandom), 64'($urandom), 4'b0010);
            step();
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair_grant%0d", i), 64'(g_log[gb+i]), 64'(i % 2));
        v[0] = 1'b0; v[1] = 1'b0;
        repeat (3) step();

        // backpressure: response held for 5 cycles while req1 waits
        do_reset();
        rsp_ready = 1'b0;
        set_op(0, 64'd100, 64'd23, 4'b0010);
        step();
        set_op(1, 64'd1, 64'd2, 4'b0001);
        gb = g_log.size(); rb = r_res.size();
        repeat (6) step();
        chk("bp_no_grant", 64'(g_log.size() - gb), 64'd0);
        chk("bp_busy",     64'(busy),             64'd1);
        chk("bp_res",      rsp_result,            64'd123);
        rsp_ready = 1'b1;
        repeat (2) step();
        chk("bp_grant1",   64'(g_log[gb]),        64'd1);
        chk("bp_after",    64'(c_log[gb] - r_cyc[rb]), 64'd1);
        repeat (3) step();

        // reset while in EXEC drops the operation
        do_reset();
        rsp_ready = 1'b1;
        rb = r_res.size();
        set_op(0, 64'd11, 64'd22, 4'b0010);
        step();
        #2 reset = 1'b1;
        #1;
        chk("rexe_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rexe_busy",      64'(busy),      64'd0);
        chk("rexe_alu_a",     alu_a,          64'd0);
        chk("rexe_alu_ctrl",  64'(alu_ctrl),  64'd0);
        chk("rexe_rsp_res",   rsp_result,     64'd0);
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        repeat (3) step();
        chk("rexe_no_rsp", 64'(r_res.size() - rb), 64'd0);
        gb = g_log.size();
        set_op(1, 64'd40, 64'd2, 4'b0110);
        repeat (4) step();
        chk("rexe_grant1", 64'(g_log[gb]), 64'd1);
        chk("rexe_res",    r_res[rb],      64'd38);

        // control code passes through untouched
        rb = r_res.size();
        set_op(0, 64'd3, 64'd5, 4'b0110);
        step();
        chk("pt_ctrl0110", 64'(alu_ctrl), 64'b0110);
        repeat (3) step();
        set_op(0, 64'd3, 64'd5, 4'b1111);
        step();
        chk("pt_ctrl1111", 64'(alu_ctrl), 64'b1111);
        repeat (3) step();
        chk("pt_res0110", r_res[rb],   64'hFFFF_FFFF_FFFF_FFFE);
        chk("pt_res1111", r_res[rb+1], 64'd8);

        // randomized traffic against the reference model
        repeat (400) begin
            for (int r = 0; r < 2; r++)
                if (!v[r] && $urandom_range(0, 2) == 0) begin
                    a[r] = {$urandom, $urandom};
                    b[r] = ($urandom_range(0, 3) == 0) ? a[r] : {$urandom, $urandom};
                    c[r] = 4'($urandom_range(0, 15));
                    v[r] = 1'b1;
                end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
